uart_tx_fifo: RTL and testbench

- Parametrised UART transmitter with an internal FIFO, for the JTAG-to-UART bridge path.
- Accepts bytes on a valid/ready handshake, buffers up to FIFO_DEPTH words, and serialises them onto a TX pin.
- Data width, parity mode, stop-bit count and baud divisor are configurable.
- Drives a board LED showing transmit activity, and exposes FIFO fill level and a sent-frame counter for debug.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_sync_fifo.sv | 54 +++++
 rtl/uart_tx_fifo.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM states, parity modes and
// the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int MAX_DATA_BITS = 9;

  // XOR of the low nbits of data; odd mode returns the inverse.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input int nbits, input int mode);
    logic p;
    p = 1'b0;
    for (int i = 0; i < MAX_DATA_BITS; i++)
      if (i < nbits) p = p ^ data[i];
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered occupancy and show-ahead read data.
// Simultaneous read and write are both honoured.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_wr, do_rd;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: valid/ready byte input, serial TX line,
// activity LED and debug fill/frame counters.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                        CLOCK_50,
  input  logic                        RESET,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        uart_txd,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [CNT_WIDTH-1:0]        frames_sent,
  output logic                        LED
);

  if (PARITY_MODE < PAR_NONE || PARITY_MODE > PAR_ODD) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_fifo: CLKS_PER_BIT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data
    $error("uart_tx_fifo: DATA_BITS must be in 5..9");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
  end

  // The bit timer also spans the whole stop period, so size it for that.
  localparam int STOP_CLKS = CLKS_PER_BIT * STOP_BITS;
  localparam int TW        = $clog2(STOP_CLKS);
  localparam int IW        = $clog2(DATA_BITS);
  localparam int LW        = $clog2(FIFO_DEPTH) + 1;

  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(STOP_CLKS - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  uart_state_e            state_q;
  logic [TW-1:0]          tmr_q;
  logic [IW-1:0]          idx_q;
  logic [DATA_BITS-1:0]   shreg_q;
  logic                   par_q;
  logic                   txd_q;
  logic [CNT_WIDTH-1:0]   frames_q;
  logic                   led_q;

  logic [DATA_BITS-1:0]   head;
  logic                   head_par;
  logic                   fifo_full, fifo_empty;
  logic [LW-1:0]          level;
  logic                   bit_done, stop_done, pop;

  assign bit_done  = (tmr_q == BIT_LAST);
  assign stop_done = (tmr_q == STOP_LAST);
  assign pop       = !fifo_empty &&
                     ((state_q == IDLE) || (state_q == STOP && stop_done));
  assign head_par  = parity_bit(MAX_DATA_BITS'(head), DATA_BITS, PARITY_MODE);

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLOCK_50),
    .rst     (RESET),
    .wr_en   (tx_valid),
    .wr_data (tx_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      txd_q    <= 1'b1;
      frames_q <= '0;
      led_q    <= 1'b0;
    end else begin
      led_q <= (state_q != IDLE) || (level != '0);
      tmr_q <= tmr_q + TW'(1);
      case (state_q)
        IDLE: begin
          tmr_q <= '0;
          txd_q <= 1'b1;
          if (pop) begin
            shreg_q <= head;
            par_q   <= head_par;
            state_q <= START;
            txd_q   <= 1'b0;
          end
        end
        START: begin
          if (bit_done) begin
            tmr_q   <= '0;
            idx_q   <= '0;
            state_q <= DATA;
            txd_q   <= shreg_q[0];
            shreg_q <= shreg_q >> 1;
          end
        end
        DATA: begin
          if (bit_done) begin
            tmr_q <= '0;
            if (idx_q == IDX_LAST) begin
              if (PARITY_MODE != PAR_NONE) begin
                state_q <= PARITY;
                txd_q   <= par_q;
              end else begin
                state_q <= STOP;
                txd_q   <= 1'b1;
              end
            end else begin
              idx_q   <= idx_q + IW'(1);
              txd_q   <= shreg_q[0];
              shreg_q <= shreg_q >> 1;
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            tmr_q   <= '0;
            state_q <= STOP;
            txd_q   <= 1'b1;
          end
        end
        STOP: begin
          if (stop_done) begin
            tmr_q    <= '0;
            frames_q <= frames_q + CNT_WIDTH'(1);
            // Chain straight into the next start bit when data is waiting.
            if (pop) begin
              shreg_q <= head;
              par_q   <= head_par;
              state_q <= START;
              txd_q   <= 1'b0;
            end else begin
              state_q <= IDLE;
              txd_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

  assign tx_ready    = !fifo_full;
  assign uart_txd    = txd_q;
  assign fifo_level  = level;
  assign frames_sent = frames_q;
  assign LED         = led_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four parameterisations, a frame-level line model,
// directed frame vectors and randomized traffic.
module tb_uart_tx_fifo;

  localparam int NCFG  = 4;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic CLOCK_50 = 1'b0;
  logic RESET;
  logic in_valid;
  logic [7:0] in_data;
  int   cur;

  logic [NCFG-1:0]       o_rdy, o_txd, o_led;
  logic [NCFG-1:0][2:0]  o_lvl;
  logic [NCFG-1:0][15:0] o_frm;

  always #5 CLOCK_50 = ~CLOCK_50;

  // cfg0 8N1, cfg1 8E1, cfg2 8O1, cfg3 7N2
  function automatic int cfg_db(input int c);  return (c == 3) ? 7 : 8; endfunction
  function automatic int cfg_par(input int c); return (c == 1) ? 1 : (c == 2) ? 2 : 0; endfunction
  function automatic int cfg_sb(input int c);  return (c == 3) ? 2 : 1; endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int P_DB  = (g == 3) ? 7 : 8;
    localparam int P_PAR = (g == 1) ? 1 : (g == 2) ? 2 : 0;
    localparam int P_SB  = (g == 3) ? 2 : 1;
    uart_tx_fifo #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (P_DB),
      .PARITY_MODE  (P_PAR),
      .STOP_BITS    (P_SB),
      .FIFO_DEPTH   (DEPTH),
      .CNT_WIDTH    (16)
    ) u_dut (
      .CLOCK_50    (CLOCK_50),
      .RESET       (RESET),
      .tx_data     (in_data[P_DB-1:0]),
      .tx_valid    (in_valid && (cur == g)),
      .tx_ready    (o_rdy[g]),
      .uart_txd    (o_txd[g]),
      .fifo_level  (o_lvl[g]),
      .frames_sent (o_frm[g]),
      .LED         (o_led[g])
    );
  end

  // Line model: expected line level for each remaining cycle of the frame in
  // flight, plus the queue of bytes waiting to be sent.
  typedef struct packed { logic b; logic last; } cyc_t;
  cyc_t       cyc_q[$];
  logic [7:0] mq[$];
  int         m_frames;
  logic       m_led;
  bit         last_wr;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cfg=%0d t=%0t got=%0h want=%0h", name, cur, $time, act, exp);
    end
  endtask

  function automatic void push_frame(input logic [7:0] d);
    bit bits[$];
    bit p;
    p = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < cfg_db(cur); i++) begin
      bits.push_back(d[i]);
      p = p ^ d[i];
    end
    if (cfg_par(cur) != 0) bits.push_back(cfg_par(cur) == 2 ? ~p : p);
    for (int i = 0; i < cfg_sb(cur); i++) bits.push_back(1'b1);
    for (int i = 0; i < bits.size(); i++)
      for (int c = 0; c < CPB; c++)
        cyc_q.push_back({bits[i], (i == bits.size() - 1) && (c == CPB - 1)});
  endfunction

  task automatic model_edge();
    int   pre_level;
    bit   pre_busy;
    cyc_t c;
    pre_level = mq.size();
    pre_busy  = cyc_q.size() > 0;
    last_wr   = in_valid && (pre_level < DEPTH);
    if (pre_busy) begin
      c = cyc_q.pop_front();
      if (c.last) m_frames++;
    end
    if (cyc_q.size() == 0 && pre_level > 0) push_frame(mq.pop_front());
    if (last_wr) mq.push_back(in_data);
    m_led = pre_busy || (pre_level != 0);
  endtask

  task automatic model_reset();
    cyc_q.delete();
    mq.delete();
    m_frames = 0;
    m_led    = 1'b0;
  endtask

  task automatic check_all();
    chk("txd",    o_txd[cur], (cyc_q.size() > 0) ? cyc_q[0].b : 1'b1);
    chk("level",  o_lvl[cur], mq.size());
    chk("ready",  o_rdy[cur], mq.size() < DEPTH);
    chk("frames", o_frm[cur], m_frames);
    chk("led",    o_led[cur], m_led);
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    model_edge();
    @(negedge CLOCK_50);
    check_all();
    in_data = 8'($urandom);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    RESET    = 1'b1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    model_reset();
    check_all();
    RESET = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    in_valid = 1'b0;
    while ((cyc_q.size() > 0 || mq.size() > 0) && g < 5000) begin
      tick();
      g++;
    end
    tick();
    tick();
  endtask

  typedef struct {
    int          cfg;
    logic [7:0]  data;
    logic [15:0] bits;   // expected line level per bit time, bit 0 first
    int          nbits;
  } vec_t;
  vec_t vt[5];

  task automatic send_vec(input vec_t v);
    int f0;
    if (v.cfg != cur) begin
      cur = v.cfg;
      do_reset();
    end
    drain();
    f0 = m_frames;
    in_valid = 1'b1;
    in_data  = v.data;
    @(posedge CLOCK_50);
    model_edge();
    @(negedge CLOCK_50);
    check_all();
    in_valid = 1'b0;
    for (int k = 0; k < v.nbits; k++) begin
      tick();
      chk("vec_bit", o_txd[cur], v.bits[k]);
      repeat (CPB - 1) tick();
    end
    tick();
    chk("vec_led_on", o_led[cur], 1);
    tick();
    chk("vec_led_off", o_led[cur], 0);
    chk("vec_frames", o_frm[cur], f0 + 1);
  endtask

  initial begin
    logic [7:0] fbytes [6];
    int idx, guard, f0;

    vt[0] = '{cfg: 0, data: 8'hA5, bits: 16'h034A, nbits: 10};
    vt[1] = '{cfg: 1, data: 8'h07, bits: 16'h060E, nbits: 11};
    vt[2] = '{cfg: 2, data: 8'h07, bits: 16'h040E, nbits: 11};
    vt[3] = '{cfg: 3, data: 8'h55, bits: 16'h03AA, nbits: 10};
    vt[4] = '{cfg: 0, data: 8'h3C, bits: 16'h0278, nbits: 10};

    RESET    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    cur      = 0;
    model_reset();
    do_reset();

    for (int i = 0; i < 5; i++) send_vec(vt[i]);

    // Back-to-back writes: the second write coincides with the first pop.
    drain();
    f0 = m_frames;
    in_valid = 1'b1;
    in_data = 8'h01; @(posedge CLOCK_50); model_edge(); @(negedge CLOCK_50); check_all();
    chk("b2b_lvl_a", o_lvl[cur], 1);
    in_data = 8'h02; @(posedge CLOCK_50); model_edge(); @(negedge CLOCK_50); check_all();
    chk("b2b_lvl_b", o_lvl[cur], 1);
    in_data = 8'h03; @(posedge CLOCK_50); model_edge(); @(negedge CLOCK_50); check_all();
    chk("b2b_lvl_c", o_lvl[cur], 2);
    in_valid = 1'b0;
    drain();
    chk("b2b_frames", o_frm[cur], f0 + 3);

    // Full FIFO: hold valid through six bytes, advancing only on accepted writes.
    f0 = m_frames;
    fbytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    idx = 0;
    guard = 0;
    in_valid = 1'b1;
    while (idx < 6 && guard < 2000) begin
      in_data = fbytes[idx];
      @(posedge CLOCK_50);
      model_edge();
      @(negedge CLOCK_50);
      check_all();
      if (last_wr) idx++;
      if (mq.size() == DEPTH) begin
        chk("full_ready", o_rdy[cur], 0);
        chk("full_level", o_lvl[cur], DEPTH);
      end
      guard++;
    end
    in_valid = 1'b0;
    chk("full_all_written", idx, 6);
    drain();
    chk("full_frames", o_frm[cur], f0 + 6);

    // Reset during data bit 3 of 0xA5 with one byte still queued.
    in_valid = 1'b1;
    in_data = 8'hA5; @(posedge CLOCK_50); model_edge(); @(negedge CLOCK_50); check_all();
    in_data = 8'h11; @(posedge CLOCK_50); model_edge(); @(negedge CLOCK_50); check_all();
    in_valid = 1'b0;
    repeat (16) tick();
    chk("rst_pre_txd", o_txd[cur], 0);
    chk("rst_pre_lvl", o_lvl[cur], 1);
    #2 RESET = 1'b1;
    #1;
    chk("rst_async_txd", o_txd[cur], 1);
    chk("rst_async_lvl", o_lvl[cur], 0);
    chk("rst_async_rdy", o_rdy[cur], 1);
    chk("rst_async_led", o_led[cur], 0);
    chk("rst_async_frm", o_frm[cur], 0);
    model_reset();
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check_all();
    RESET = 1'b0;
    send_vec(vt[4]);

    // Randomized traffic on every configuration, sparse then dense.
    for (int c = 0; c < NCFG; c++) begin
      cur = c;
      do_reset();
      for (int n = 0; n < 400; n++) begin
        in_valid = (n < 200) ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 3) == 0);
        @(posedge CLOCK_50);
        model_edge();
        @(negedge CLOCK_50);
        check_all();
        in_data = 8'($urandom);
      end
      drain();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
